uart_tx_ctrl: RTL and testbench

Transmit controller for the UART transmitter. It accepts a parallel byte over a valid/ready handshake and generates the bit-period timing. It sequences the load/shift select for the frame shift register and drives the serial line with start, data (LSB first) and stop bits. It sits between the host-side byte source and the TX pin. It also exports the load and shift strobes so an external mux/DFF shift chain can be run in lockstep.

---
 rtl/uart_tx_ctrl.sv | 139 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: byte handshake, bit timing,
// frame shift register and load/shift strobes for a shift chain.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 load,
  output logic                 shift
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int SW = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [SW-1:0] sr;
  logic [SW-1:0] sr_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic          load_n;
  logic          shift_n;
  logic          done_n;
  logic          busy_n;
  logic          bit_end;
  logic          accept;

  assign tx_ready = (state == IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = (cnt == CNT_LAST);
  assign tx_out   = sr[0];

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    idx_n   = idx;
    load_n  = 1'b0;
    shift_n = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        sr_n  = '1;
        cnt_n = '0;
        idx_n = '0;
        if (accept) begin
          sr_n    = {1'b1, tx_data, 1'b0};
          load_n  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          sr_n    = {1'b1, sr[SW-1:1]};
          shift_n = 1'b1;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          sr_n    = {1'b1, sr[SW-1:1]};
          shift_n = 1'b1;
          if (idx == IDX_LAST) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        // stop bit already sits in sr[0]; no shift here
        if (bit_end) begin
          cnt_n   = '0;
          sr_n    = '1;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        sr_n    = '1;
        cnt_n   = '0;
        idx_n   = '0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '1;
      cnt     <= '0;
      idx     <= '0;
      load    <= 1'b0;
      shift   <= 1'b0;
      tx_done <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      load    <= load_n;
      shift   <= shift_n;
      tx_done <= done_n;
      tx_busy <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a
// cycle-indexed frame model (8-bit/4-clk and 5-bit/2-clk).
module tb_uart_tx_ctrl;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;
  logic       load;
  logic       shift;

  logic       tx_valid5;
  logic [4:0] tx_data5;
  logic       tx_ready5;
  logic       tx_out5;
  logic       tx_busy5;
  logic       tx_done5;
  logic       load5;
  logic       shift5;

  int n_checks;
  int n_fail;

  localparam int N = 128;

  logic [4:0] s8  [0:N-1];
  logic       s8r [0:N-1];
  logic [4:0] s5  [0:N-1];
  logic       st_v  [0:N-1];
  logic [7:0] st_d  [0:N-1];
  logic       st_r  [0:N-1];
  logic       st_v5 [0:N-1];
  logic [4:0] st_d5 [0:N-1];

  uart_tx_ctrl #(
    .CLKS_PER_BIT(4),
    .DATA_BITS   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx_out  (tx_out),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .load    (load),
    .shift   (shift)
  );

  uart_tx_ctrl #(
    .CLKS_PER_BIT(2),
    .DATA_BITS   (5)
  ) dut5 (
    .clk     (clk),
    .rst     (rst),
    .tx_valid(tx_valid5),
    .tx_data (tx_data5),
    .tx_ready(tx_ready5),
    .tx_out  (tx_out5),
    .tx_busy (tx_busy5),
    .tx_done (tx_done5),
    .load    (load5),
    .shift   (shift5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // Expected {line, load, shift, done, busy} k cycles after
  // the start bit of a frame begins (k<0: before the frame).
  function automatic logic [4:0] frame_vec(
    input logic [7:0] d, input int nb, input int cpb,
    input int k);
    int   f;
    int   b;
    logic ln, ld, sh, dn, by;
    f  = (nb + 2) * cpb;
    ln = 1'b1;
    ld = (k == 0);
    sh = 1'b0;
    dn = (k == f);
    by = (k >= 0) && (k < f);
    if (by) begin
      b = k / cpb;
      if (b == 0) ln = 1'b0;
      else if (b <= nb) ln = d[b-1];
      else ln = 1'b1;
      sh = (k > 0) && (k % cpb == 0);
    end
    return {ln, ld, sh, dn, by};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      st_v[i]  = 1'b0;
      st_d[i]  = 8'h00;
      st_r[i]  = 1'b0;
      st_v5[i] = 1'b0;
      st_d5[i] = 5'h00;
    end
  endtask

  // Samples at the current negedge, then each following one,
  // applying per-cycle stimulus after each sample.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      s8[i]  = {tx_out, load, shift, tx_done, tx_busy};
      s8r[i] = tx_ready;
      s5[i]  = {tx_out5, load5, shift5, tx_done5, tx_busy5};
      tx_valid  = st_v[i];
      tx_data   = st_d[i];
      rst       = st_r[i];
      tx_valid5 = st_v5[i];
      tx_data5  = st_d5[i];
    end
  endtask

  task automatic idle_gap(input int n);
    tx_valid  = 1'b0;
    tx_valid5 = 1'b0;
    rst       = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start8(input logic [7:0] d);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({tx_out, tx_busy, tx_ready, tx_done, load, shift}
          !== 6'b100000) begin
        n_fail++;
        $display("FAIL reset[%0d] out/busy/rdy/done/ld/sh=%b want 100000",
                 i, {tx_out, tx_busy, tx_ready, tx_done, load, shift});
      end
      n_checks++;
      if ({tx_out5, tx_busy5, tx_ready5} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset5[%0d] out/busy/rdy=%b want 100",
                 i, {tx_out5, tx_busy5, tx_ready5});
      end
    end
    tx_valid = 1'b0;
    rst      = 1'b0;
    #1;
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release tx_ready=%b want 1", tx_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({tx_out, tx_busy, load} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_no_frame out/busy/load=%b want 100",
               {tx_out, tx_busy, load});
    end
  endtask

  task automatic test_single_frame();
    int nsh;
    clear_stim();
    start8(8'hA5);
    capture(48);
    nsh = 0;
    for (int j = 0; j < 48; j++) begin
      n_checks++;
      if (s8[j] !== frame_vec(8'hA5, 8, 4, j)) begin
        n_fail++;
        $display("FAIL single j=%0d got=%b want=%b",
                 j, s8[j], frame_vec(8'hA5, 8, 4, j));
      end
      if (s8[j][2]) nsh++;
    end
    n_checks++;
    if (nsh != 9) begin
      n_fail++;
      $display("FAIL single_shift_count got=%0d want=9", nsh);
    end
    n_checks++;
    if ({s8r[39], s8r[40]} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready got=%b want=01",
               {s8r[39], s8r[40]});
    end
    idle_gap(3);
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom);
      clear_stim();
      start8(d);
      capture(44);
      for (int j = 0; j < 44; j++) begin
        n_checks++;
        if (s8[j] !== frame_vec(d, 8, 4, j)) begin
          n_fail++;
          $display("FAIL random d=%h j=%0d got=%b want=%b",
                   d, j, s8[j], frame_vec(d, 8, 4, j));
        end
      end
      idle_gap(1 + $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    int         nd;
    int         run;
    clear_stim();
    for (int j = 0; j < N; j++) begin
      st_v[j] = (j < 41);
      st_d[j] = 8'hFF;
    end
    start8(8'h00);
    capture(90);
    nd = 0;
    for (int j = 0; j < 90; j++) begin
      e = (j < 41) ? frame_vec(8'h00, 8, 4, j)
                   : frame_vec(8'hFF, 8, 4, j - 41);
      n_checks++;
      if (s8[j] !== e) begin
        n_fail++;
        $display("FAIL b2b j=%0d got=%b want=%b", j, s8[j], e);
      end
      if (s8[j][1]) nd++;
    end
    n_checks++;
    if (nd != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count got=%0d want=2", nd);
    end
    run = 0;
    for (int j = 40; j >= 0 && s8[j][4]; j--) run++;
    n_checks++;
    if (run != 5) begin
      n_fail++;
      $display("FAIL b2b_stop_len got=%0d want=5", run);
    end
    idle_gap(3);
  endtask

  task automatic test_busy_stable();
    int nl;
    clear_stim();
    for (int j = 0; j < N; j++) begin
      st_v[j] = (j < 38) ? logic'(j % 2) : 1'b0;
      st_d[j] = 8'hFF;
    end
    start8(8'h3C);
    capture(60);
    nl = 0;
    for (int j = 0; j < 60; j++) begin
      n_checks++;
      if (s8[j] !== frame_vec(8'h3C, 8, 4, j)) begin
        n_fail++;
        $display("FAIL busy j=%0d got=%b want=%b",
                 j, s8[j], frame_vec(8'h3C, 8, 4, j));
      end
      if (s8[j][3]) nl++;
    end
    n_checks++;
    if (nl != 1) begin
      n_fail++;
      $display("FAIL busy_load_count got=%0d want=1", nl);
    end
    idle_gap(3);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d0;
    logic [4:0] e;
    d0 = 8'($urandom);
    clear_stim();
    st_r[17] = 1'b1;
    st_v[20] = 1'b1;
    st_d[20] = 8'h81;
    start8(d0);
    capture(66);
    for (int j = 0; j < 66; j++) begin
      if (j <= 17) e = frame_vec(d0, 8, 4, j);
      else if (j <= 20) e = 5'b10000;
      else e = frame_vec(8'h81, 8, 4, j - 21);
      n_checks++;
      if (s8[j] !== e) begin
        n_fail++;
        $display("FAIL rst_mid d0=%h j=%0d got=%b want=%b",
                 d0, j, s8[j], e);
      end
    end
    n_checks++;
    if ({s8r[18], s8r[19]} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_ready got=%b want=01",
               {s8r[18], s8r[19]});
    end
    idle_gap(3);
  endtask

  task automatic test_five_bits();
    int nsh;
    clear_stim();
    @(negedge clk);
    tx_valid5 = 1'b1;
    tx_data5  = 5'h13;
    @(negedge clk);
    capture(18);
    nsh = 0;
    for (int j = 0; j < 18; j++) begin
      n_checks++;
      if (s5[j] !== frame_vec(8'h13, 5, 2, j)) begin
        n_fail++;
        $display("FAIL five j=%0d got=%b want=%b",
                 j, s5[j], frame_vec(8'h13, 5, 2, j));
      end
      if (s5[j][2]) nsh++;
    end
    n_checks++;
    if (nsh != 6) begin
      n_fail++;
      $display("FAIL five_shift_count got=%0d want=6", nsh);
    end
    idle_gap(3);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_valid5 = 1'b0;
    tx_data5  = 5'h00;
    test_reset();
    idle_gap(2);
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_busy_stable();
    test_reset_mid_frame();
    test_five_bits();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
